// File: rtl/sudoku_pkg.sv
// Shared encodings and group-to-cell mapping for the 4x4 Sudoku checker.
package sudoku_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SCAN = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int          N_GROUPS    = 12;
  localparam logic [3:0]  NO_CONFLICT = 4'hF;

  // Groups 0..3 rows, 4..7 columns, 8..11 boxes; slots in ascending cell order.
  function automatic logic [3:0] group_cell(input logic [3:0] g, input logic [1:0] s);
    logic [3:0] b;
    b = '0;
    if (g < 4'd4) begin
      return {g[1:0], s};
    end else if (g < 4'd8) begin
      b = g - 4'd4;
      return {s, b[1:0]};
    end else begin
      b = g - 4'd8;
      return {b[1], s[1], b[0], s[0]};
    end
  endfunction
endpackage

// File: rtl/sudoku_group_check.sv
// Combinational check of one constraint group: duplicates, illegal values, empties.
module sudoku_group_check #(
  parameter int W = 4
) (
  input  logic [3:0][W-1:0] cells,
  output logic              fail,
  output logic              any_empty
);
  always_comb begin
    fail      = 1'b0;
    any_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cells[i] > W'(4)) fail = 1'b1;
      if (cells[i] == '0)   any_empty = 1'b1;
      for (int j = i + 1; j < 4; j++)
        if (cells[i] != '0 && cells[i] == cells[j]) fail = 1'b1;
    end
  end
endmodule

// File: rtl/sudoku_grid_ctrl.sv
// Grid store plus load/scan/done sequencer; scans one constraint group per cycle.
module sudoku_grid_ctrl
  import sudoku_pkg::*;
#(
  parameter int CELL_W   = 4,
  parameter int N_GROUPS = 12
) (
  input  logic       in_clka,
  input  logic       in_restart,
  input  logic       in_load,
  input  logic       in_wr,
  input  logic       in_start,
  input  logic [3:0] in_d1_in,
  input  logic [3:0] in_d2_in,
  output logic       out_start,
  output logic [1:0] out_state_main,
  output logic [3:0] out_d_out,
  output logic       out_done,
  output logic       out_valid,
  output logic       out_solved
);
  localparam logic [3:0] LAST_GRP = 4'(N_GROUPS - 1);

  state_e            state_q, state_d;
  logic [CELL_W-1:0] grid_q [16];
  logic [CELL_W-1:0] grid_d [16];
  logic [3:0]        cnt_q, cnt_d, first_q, first_d, d_out_q, d_out_d;
  logic              empty_q, empty_d, start_q, start_d, done_q, done_d;
  logic              valid_q, valid_d, solved_q, solved_d;
  logic              enter_scan, grp_fail, grp_empty;
  logic [3:0][CELL_W-1:0] grp_cells;

  always_comb begin
    for (int s = 0; s < 4; s++)
      grp_cells[s] = grid_q[group_cell(cnt_q, 2'(s))];
  end

  sudoku_group_check #(.W(CELL_W)) u_check (
    .cells     (grp_cells),
    .fail      (grp_fail),
    .any_empty (grp_empty)
  );

  always_comb begin
    state_d    = state_q;
    grid_d     = grid_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    empty_d    = empty_q;
    d_out_d    = d_out_q;
    valid_d    = valid_q;
    solved_d   = solved_q;
    start_d    = 1'b0;
    enter_scan = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_load)       state_d = ST_LOAD;
        else if (in_start) enter_scan = 1'b1;
      end
      ST_LOAD: begin
        if (in_wr) grid_d[in_d2_in] = CELL_W'(in_d1_in);
        if (in_start) enter_scan = 1'b1;
      end
      ST_SCAN: begin
        if (grp_fail && first_q == NO_CONFLICT) first_d = cnt_q;
        // Every cell belongs to exactly one row, so rows alone cover emptiness.
        if (cnt_q < 4'd4 && grp_empty) empty_d = 1'b1;
        if (cnt_q == LAST_GRP) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          d_out_d  = first_d;
          valid_d  = (first_d == NO_CONFLICT);
          solved_d = (first_d == NO_CONFLICT) && !empty_d;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (in_load)       state_d = ST_LOAD;
        else if (in_start) enter_scan = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_scan) begin
      state_d  = ST_SCAN;
      start_d  = 1'b1;
      cnt_d    = '0;
      first_d  = NO_CONFLICT;
      empty_d  = 1'b0;
      d_out_d  = NO_CONFLICT;
      valid_d  = 1'b0;
      solved_d = 1'b0;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < 16; i++) grid_q[i] <= '0;
      cnt_q    <= '0;
      first_q  <= NO_CONFLICT;
      empty_q  <= 1'b0;
      d_out_q  <= NO_CONFLICT;
      valid_q  <= 1'b0;
      solved_q <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      empty_q  <= empty_d;
      d_out_q  <= d_out_d;
      valid_q  <= valid_d;
      solved_q <= solved_d;
      start_q  <= start_d;
      done_q   <= done_d;
    end
  end

  assign out_start      = start_q;
  assign out_state_main = state_q;
  assign out_d_out      = d_out_q;
  assign out_done       = done_q;
  assign out_valid      = valid_q;
  assign out_solved     = solved_q;
endmodule

// File: tb/tb_sudoku_grid_ctrl.sv
// Directed bench for sudoku_grid_ctrl: load, scan timing, conflicts, rescan, restart.
module tb_sudoku_grid_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0, wr = 1'b0, start = 1'b0;
  logic [3:0] d1 = '0, d2 = '0;
  logic       o_start, o_done, o_valid, o_solved;
  logic [1:0] o_state;
  logic [3:0] o_dout;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  sudoku_grid_ctrl #(.CELL_W(4), .N_GROUPS(12)) dut (
    .in_clka        (clk),
    .in_restart     (rst),
    .in_load        (load),
    .in_wr          (wr),
    .in_start       (start),
    .in_d1_in       (d1),
    .in_d2_in       (d2),
    .out_start      (o_start),
    .out_state_main (o_state),
    .out_d_out      (o_dout),
    .out_done       (o_done),
    .out_valid      (o_valid),
    .out_solved     (o_solved)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr_cell(input int idx, input int val);
    wr = 1'b1; d2 = idx[3:0]; d1 = val[3:0];
    tick();
    wr = 1'b0;
  endtask

  // Start in the current cycle, verify entry, then exact 12-cycle latency and results.
  task automatic scan(input string tag, input logic [3:0] ed, input logic ev, input logic es);
    start = 1'b1;
    tick();
    start = 1'b0; wr = 1'b0;
    chk({tag, "_entry_state"}, 8'(o_state), 8'h2);
    chk({tag, "_entry_pulse"}, 8'(o_start), 8'h1);
    chk({tag, "_entry_dout"},  8'(o_dout),  8'hF);
    chk({tag, "_entry_valid"}, 8'(o_valid), 8'h0);
    repeat (11) tick();
    chk({tag, "_not_done_k11"}, {6'(o_state), 1'b0, o_done}, {6'h2, 1'b0, 1'b0});
    tick();
    chk({tag, "_done"},   8'(o_done),   8'h1);
    chk({tag, "_state"},  8'(o_state),  8'h3);
    chk({tag, "_dout"},   8'(o_dout),   8'(ed));
    chk({tag, "_valid"},  8'(o_valid),  8'(ev));
    chk({tag, "_solved"}, 8'(o_solved), 8'(es));
    chk({tag, "_pulse_low"}, 8'(o_start), 8'h0);
  endtask

  initial begin
    logic [3:0] sol [16];
    sol = '{4'd1,4'd2,4'd3,4'd4, 4'd3,4'd4,4'd1,4'd2, 4'd2,4'd1,4'd4,4'd3, 4'd4,4'd3,4'd2,4'd1};
    #12;
    chk("rst_state",  8'(o_state),  8'h0);
    chk("rst_dout",   8'(o_dout),   8'hF);
    chk("rst_flags",  {4'h0, o_start, o_done, o_valid, o_solved}, 8'h0);
    rst = 1'b0;
    tick();

    // Empty grid: no conflicts, not solved.
    scan("empty", 4'hF, 1'b1, 1'b0);

    load = 1'b1; tick(); load = 1'b0;
    chk("load_from_done", 8'(o_state), 8'h1);
    for (int i = 0; i < 16; i++) wr_cell(i, int'(sol[i]));
    scan("solved", 4'hF, 1'b1, 1'b1);

    // Column 0 duplicate is found before box 0.
    load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 16; i++) wr_cell(i, 0);
    wr_cell(0, 1);
    wr_cell(4, 1);
    scan("col_dup", 4'h4, 1'b0, 1'b0);

    load = 1'b1; tick(); load = 1'b0;
    wr_cell(0, 0);
    wr_cell(4, 0);
    wr_cell(6, 9);
    scan("illegal", 4'h1, 1'b0, 1'b0);
    scan("rescan", 4'h1, 1'b0, 1'b0);

    // Write coinciding with start lands; writes during SCAN are dropped.
    load = 1'b1; tick(); load = 1'b0;
    wr_cell(6, 0);
    wr_cell(4, 3);
    wr = 1'b1; d2 = 4'd5; d1 = 4'd2; start = 1'b1;
    tick();
    start = 1'b0; d1 = 4'd3;
    chk("wr_start_state", 8'(o_state), 8'h2);
    repeat (11) tick();
    wr = 1'b0;
    tick();
    chk("wr_scan_done",  8'(o_done),  8'h1);
    chk("wr_scan_dout",  8'(o_dout),  8'hF);
    chk("wr_scan_valid", 8'(o_valid), 8'h1);
    scan("grid_kept2", 4'hF, 1'b1, 1'b0);
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk("load_over_start", 8'(o_state), 8'h1);

    // Asynchronous restart in mid-scan over a conflicting grid.
    wr_cell(0, 1);
    wr_cell(1, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_state", 8'(o_state), 8'h2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 8'(o_state), 8'h0);
    chk("arst_dout",  8'(o_dout),  8'hF);
    chk("arst_flags", {4'h0, o_start, o_done, o_valid, o_solved}, 8'h0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_idle", 8'(o_state), 8'h0);
    scan("after_rst", 4'hF, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/sudoku_grid_ctrl.md
# sudoku_grid_ctrl

Sequencing controller and grid store for the 4x4 Sudoku checker. It accepts cell writes during a load phase, then scans all 12 constraint groups one per cycle. Each group is a row, column or 2x2 box. It then reports the first conflicting group and grid validity/completeness. It sits between the top-level load/restart controls and the result outputs, and drives the main-state indication.

## Interface
Parameters:
- CELL_W, 4, stored cell width (matches data-in width)
- N_GROUPS, 12, constraint groups scanned (4 rows, 4 cols, 4 boxes)

Ports:
- in_clka  input  1  single system clock, rising edge
- in_restart  input  1  reset, asynchronous, active-high
- in_load  input  1  enter LOAD from IDLE or DONE
- in_wr  input  1  write strobe, honoured only in LOAD
- in_start  input  1  begin scan from LOAD, IDLE or DONE
- in_d1_in  input  4  cell value (0 = empty, 1..4 legal, 5..15 illegal)
- in_d2_in  input  4  cell index = row*4 + col
- out_start  output  1  one-cycle pulse on first SCAN cycle
- out_state_main  output  2  IDLE=00, LOAD=01, SCAN=10, DONE=11
- out_d_out  output  4  index of first failing group, 4'hF if none
- out_done  output  1  high while in DONE
- out_valid  output  1  no group conflict
- out_solved  output  1  out_valid and no empty cell

## Operation
- Grid: 16 x 4-bit registers.
  - Cleared to 0 by reset only.
  - in_load does not clear the grid.
- Group g, cells in ascending index order:
  - 0..3: row g.
  - 4..7: column g-4.
  - 8..11: box b=g-8, covering rows 2*(b/2)..+1 and cols 2*(b%2)..+1.
- A group fails if either condition holds:
  - Two of its cells hold the same nonzero value.
  - Any of its cells holds a value greater than 4.
- FSM, evaluated at each rising edge, in_restart overriding all:
  - IDLE: in_load goes to LOAD; otherwise in_start goes to SCAN; otherwise stay.
  - LOAD: when in_wr=1, grid[in_d2_in] <= in_d1_in. in_start goes to SCAN, and a write in that same cycle still lands. in_load is ignored.
  - SCAN: a 4-bit group counter runs 0..11. Group failure is registered each cycle, and the first failing index is latched. After group 11 the FSM goes to DONE. in_load, in_start and in_wr are ignored.
  - DONE: results are held. in_load goes to LOAD and takes priority over in_start. in_start goes to SCAN, which rescans the unchanged grid.
- On SCAN entry:
  - out_d_out becomes 4'hF; out_valid and out_solved become 0.
  - The internal empty-cell flag is cleared; it accumulates over row groups 0..3.
- On DONE entry:
  - out_d_out = first failing group, or 4'hF.
  - out_valid = (no failure).
  - out_solved = out_valid and no zero cell.

## Timing
- Reset values:
  - out_start=0, out_state_main=00, out_d_out=4'hF, out_done=0, out_valid=0, out_solved=0.
  - Group counter=0, grid all 0.
- Reset mid-operation (any state) returns to IDLE immediately and asynchronously; the grid is cleared and no partial results remain.
- Scan latency:
  - in_start is sampled high at edge k.
  - SCAN occupies cycles k..k+11; out_start is high for cycle k only.
  - DONE, out_done and the results all appear at edge k+12.
- A write accepted at edge k is visible to a scan started at edge k or later.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package sudoku_pkg holds:
  - State encodings, N_GROUPS, NO_CONFLICT=4'hF.
  - Group-to-cell index function (group, slot -> cell index).
- Sub-module sudoku_group_check is purely combinational:
  - Takes four 4-bit cells.
  - Returns a fail flag (duplicate nonzero or value > 4) and an any-empty flag.
- The controller owns the FSM, grid, counter and result registers.

## Test plan
- Reset, then in_start with no load: SCAN for 12 cycles -> out_done=1, out_d_out=F, out_valid=1, out_solved=0.
- Load rows 1234/3412/2143/4321 via 16 writes, then start -> out_d_out=F, out_valid=1, out_solved=1, exactly 12 cycles after start.
- Load cell0=1, cell4=1, rest 0 -> out_d_out=4 (column 0 precedes box 0), out_valid=0.
- Load cell6=9 -> out_d_out=1, out_valid=0; rescan from DONE via in_start -> same result.
- Assert in_wr (cell5=2) in the same cycle as in_start, then hold in_wr in SCAN (cell5=3) -> scan sees 2 and grid keeps 2; in DONE with in_load and in_start both high -> LOAD.
- Assert in_restart at SCAN cycle 5 -> all outputs at reset values immediately, grid zero, state IDLE; following start -> out_valid=1, out_solved=0.
